mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register outputs (instr_M, ALUout_M, WriteData_M, PC_M, WRegAdd_M).
//  Runs loads/stores over a req/ack data bus with byte lanes and sign/zero-extends load data.
//  Stalls the pipeline while an access is outstanding, then registers the MEM/WB-side results.
// PARAMETERS
//  RESET_PC  32'h0000_3000  reset value of PC_W
//  TIMEOUT   255            max WAIT cycles before the access is abandoned (1..255)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  instr_M      in   32  instruction in MEM stage
//  ALUout_M     in   32  effective address / ALU result
//  WriteData_M  in   32  store data (forwarded rt)
//  PC_M         in   32  PC of instr_M
//  WRegAdd_M    in   5   destination register
//  bus_ack      in   1   memory completes access this cycle
//  bus_rdata    in   32  read data, valid with bus_ack
//  bus_req      out  1   access request
//  bus_we       out  1   1=store
//  bus_addr     out  32  {ALUout_M[31:2],2'b00}
//  bus_be       out  4   byte enables
//  bus_wdata    out  32  lane-replicated store data
//  stall_M      out  1   freeze PC/IF_ID/ID_EX/EX_MEM this cycle
//  instr_W, ALUout_W, PC_W  out 32  registered to WB
//  RData_W      out  32  extended load data
//  WRegAdd_W    out  5   registered dest (0 on bubble/exception)
//  exc_W        out  2   registered: 01 misaligned, 10 bus timeout, 00 none
// BEHAVIOUR
//  Decode on instr_M[31:26]: lw 23h, lh 21h, lhu 25h, lb 20h, lbu 24h, sw 2Bh, sh 29h, sb 28h; all others non-mem.
//  Misaligned: lw/sw addr[1:0]!=0, lh/lhu/sh addr[0]!=0 -> no bus access, no stall, exc_W<=01, WRegAdd_W<=0.
//  FSM states IDLE, WAIT, DONE:
//   IDLE: mem op aligned -> bus_req=1; bus_ack same cycle -> DONE, else -> WAIT.
//   WAIT: bus_req held, addr/we/be/wdata stable; bus_ack -> DONE; TIMEOUT cycles w/o ack -> DONE with timeout flag.
//   DONE: bus_req=0, stall_M=0, results latched to W; -> IDLE unconditionally.
//  stall_M = aligned mem op & state!=DONE (combinational). Min memory op cost: 1 stall cycle.
//  bus_req = (IDLE & aligned mem op) | WAIT; bus_ack in IDLE/DONE with no request is ignored.
//  Read data captured into holding reg on bus_ack; timeout -> holding reg 0, exc_W<=10, WRegAdd_W<=0.
//  Byte lanes (little-endian, a=addr[1:0]): sw be=1111; sh be=a[1]?1100:0011, wdata={2{wd[15:0]}};
//   sb be=1<<a, wdata={4{wd[7:0]}}.
//  Loads: lb/lbu select byte a, lh/lhu select half a[1]; sign-extend lb/lh, zero-extend lbu/lhu; lw as-is.
//  W regs: posedge & !stall_M -> latch instr/ALUout/PC/WRegAdd/RData/exc;
//   stall_M -> bubble (instr_W=0, WRegAdd_W=0, exc_W=00, others hold).
//  Non-mem ops pass through with 0 added latency; RData_W=0.
//  Reset low: state IDLE, counter 0, all W outputs 0 except PC_W=RESET_PC; bus_req drops immediately.
//  Reset mid-WAIT abandons the access; late ack after reset ignored. Upstream must hold EX/MEM while stall_M.
// STRUCTURE
//  mips_pkg: opcode constants, FSM state encoding (2 bits), exc codes, RESET_PC default.
//  Sub-module lsu_lane_align (combinational): be/wdata generation and load select/extend.
//  Top: FSM, 8-bit timeout counter, read holding reg, MEM/WB register bank.
// TESTING
//  lw addr 0x0000_0010, ack 2 cycles after req -> stall_M 3 cycles, RData_W=bus_rdata, WRegAdd_W=rt.
//  lb addr 0x...03, bus_rdata=0x80FF_0000 -> RData_W=0xFFFF_FF80; lbu -> 0x0000_0080.
//  sh addr 0x...02, WriteData_M=0x1234_ABCD -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1.
//  lw addr 0x...01 -> bus_req=0, stall_M=0, exc_W=01, WRegAdd_W=0.
//  lw, no ack for TIMEOUT=4 -> stall released after 4 WAIT cycles, exc_W=10, RData_W=0.
//  reset low during WAIT -> bus_req=0 same cycle, PC_W=0x3000, ack on next cycle ignored, FSM IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Contents: MIPS load/store opcodes, the FSM state encoding (2 bits), exception
// codes, the default reset PC, and helpers that decode an opcode into a memory
// operation descriptor and check its alignment.
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic      is_load;
        logic      is_store;
        mem_size_t size;
        logic      sign_ext;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        mem_op_t d;
        d.is_load  = 1'b0;
        d.is_store = 1'b0;
        d.size     = SZ_WORD;
        d.sign_ext = 1'b0;
        case (opcode)
            OP_LW:  begin d.is_load = 1'b1;  d.size = SZ_WORD; end
            OP_LH:  begin d.is_load = 1'b1;  d.size = SZ_HALF; d.sign_ext = 1'b1; end
            OP_LHU: begin d.is_load = 1'b1;  d.size = SZ_HALF; end
            OP_LB:  begin d.is_load = 1'b1;  d.size = SZ_BYTE; d.sign_ext = 1'b1; end
            OP_LBU: begin d.is_load = 1'b1;  d.size = SZ_BYTE; end
            OP_SW:  begin d.is_store = 1'b1; d.size = SZ_WORD; end
            OP_SH:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
            OP_SB:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
            default: ;
        endcase
        return d;
    endfunction

    // Word accesses need a[1:0]==0, halfword accesses need a[0]==0.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
        logic m;
        m = 1'b0;
        if (op.is_load || op.is_store) begin
            case (op.size)
                SZ_WORD: m = (a != 2'b00);
                SZ_HALF: m = a[0];
                default: m = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data bus between the load/store unit (master) and memory (slave).
// req/we/addr/be/wdata: request side, held stable until ack.
// ack/rdata: memory completes the access; rdata valid with ack.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
// Inputs : op (decoded memory op), byte_off (addr[1:0]), store_data, load_word.
// Outputs: be (byte enables), wdata (lane-replicated store data),
//          load_data (selected and sign/zero-extended load result).
// Little-endian: byte 0 lives in bits [7:0].
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] lane_bytes [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lanes
            assign lane_bytes[gi] = load_word[8*gi +: 8];
        end
    endgenerate

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
        sel_byte  = lane_bytes[byte_off];
        sel_half  = byte_off[1] ? load_word[31:16] : load_word[15:0];
        case (op.size)
            SZ_BYTE: begin
                be        = 4'b0001 << byte_off;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{op.sign_ext & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                be        = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{op.sign_ext & sel_half[15]}}, sel_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit.
// Consumes the EX/MEM register outputs, runs loads/stores over a req/ack bus,
// stalls the pipeline while an access is outstanding and registers results
// towards WB.
// Ports:
//   clk, reset (asynchronous, active-low)
//   instr_M, ALUout_M, WriteData_M, PC_M, WRegAdd_M : MEM-stage inputs
//   bus (master modport)                             : data bus
//   stall_M                                          : pipeline freeze
//   instr_W, ALUout_W, PC_W, RData_W, WRegAdd_W, exc_W : MEM/WB registers
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr_M,
    input  logic [31:0]        ALUout_M,
    input  logic [31:0]        WriteData_M,
    input  logic [31:0]        PC_M,
    input  logic [4:0]         WRegAdd_M,
    mem_access_unit_if.master  bus,
    output logic               stall_M,
    output logic [31:0]        instr_W,
    output logic [31:0]        ALUout_W,
    output logic [31:0]        PC_W,
    output logic [31:0]        RData_W,
    output logic [4:0]         WRegAdd_W,
    output logic [1:0]         exc_W
);

    // Counter value on the last WAIT cycle before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_op_t op;
    logic    is_mem;
    logic    misaligned;
    logic    aligned_mem;

    assign op          = decode_mem_op(instr_M[31:26]);
    assign is_mem      = op.is_load | op.is_store;
    assign misaligned  = is_mem & is_misaligned(op, ALUout_M[1:0]);
    assign aligned_mem = is_mem & ~misaligned;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic [31:0] hold_reg, hold_next;
    logic        tout_reg, tout_next;
    logic        req_raw;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    lsu_lane_align u_lane_align (
        .op         (op),
        .byte_off   (ALUout_M[1:0]),
        .store_data (WriteData_M),
        .load_word  (hold_reg),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            hold_reg  <= '0;
            tout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            hold_reg  <= hold_next;
            tout_reg  <= tout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        hold_next  = hold_reg;
        tout_next  = tout_reg;
        req_raw    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (aligned_mem) begin
                    req_raw    = 1'b1;
                    count_next = '0;
                    tout_next  = 1'b0;
                    if (bus.ack) begin
                        hold_next  = bus.rdata;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                req_raw = 1'b1;
                if (bus.ack) begin
                    hold_next  = bus.rdata;
                    tout_next  = 1'b0;
                    state_next = ST_DONE;
                end else if (count_reg == TO_LAST) begin
                    hold_next  = '0;
                    tout_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The request is gated by reset so it drops the moment reset asserts,
    // even while instr_M still holds a memory op.
    assign bus.req   = reset & req_raw;
    assign bus.we    = op.is_store;
    assign bus.addr  = {ALUout_M[31:2], 2'b00};
    assign bus.be    = lane_be;
    assign bus.wdata = lane_wdata;

    assign stall_M = aligned_mem & (state_reg != ST_DONE);

    // An aligned memory op only reaches WB in DONE, so tout_reg is fresh there.
    logic [1:0]  exc_next;
    logic [4:0]  wreg_next;
    logic [31:0] rdata_next;

    always_comb begin
        exc_next   = EXC_NONE;
        wreg_next  = WRegAdd_M;
        rdata_next = op.is_load ? load_data : 32'h0;
        if (misaligned) begin
            exc_next   = EXC_MISALIGN;
            wreg_next  = '0;
            rdata_next = '0;
        end else if (aligned_mem && tout_reg) begin
            exc_next   = EXC_TIMEOUT;
            wreg_next  = '0;
            rdata_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_W   <= '0;
            ALUout_W  <= '0;
            PC_W      <= RESET_PC;
            RData_W   <= '0;
            WRegAdd_W <= '0;
            exc_W     <= EXC_NONE;
        end else if (stall_M) begin
            // Bubble into WB; data registers hold.
            instr_W   <= '0;
            WRegAdd_W <= '0;
            exc_W     <= EXC_NONE;
        end else begin
            instr_W   <= instr_M;
            ALUout_W  <= ALUout_M;
            PC_W      <= PC_M;
            RData_W   <= rdata_next;
            WRegAdd_W <= wreg_next;
            exc_W     <= exc_next;
        end
    end

endmodule
